// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// alu_muldiv_if : request/result handshake bundle for the iterative mul/div unit
// Revision 1.0
// ============================================================================
interface alu_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Out_ALU;

    modport master (
        output in_valid, op, A, B, flush, out_ready,
        input  in_ready, out_valid, Out_ALU
    );

    modport slave (
        input  in_valid, op, A, B, flush, out_ready,
        output in_ready, out_valid, Out_ALU
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// alu_muldiv : iterative RV-style multiply/divide, one bit per cycle
// Revision 1.0
// ============================================================================
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_muldiv_if.slave bus
);

    localparam int            CW   = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   out_q;

    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_d;

    // Operand decode at acceptance: signedness, magnitudes, short-cut cases
    always_comb begin
        a_sgn    = (bus.op != 3'b011) && (bus.op != 3'b101) && (bus.op != 3'b111);
        b_sgn    = a_sgn && (bus.op != 3'b010);
        a_neg    = a_sgn && bus.A[XLEN-1];
        b_neg    = b_sgn && bus.B[XLEN-1];
        a_mag    = a_neg ? -bus.A : bus.A;
        b_mag    = b_neg ? -bus.B : bus.B;
        div_zero = bus.op[2] && (bus.B == '0);
        div_ovf  = ((bus.op == 3'b100) || (bus.op == 3'b110))
                   && (bus.A == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.B == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.A : '1;
        end else if (div_ovf) begin
            special_res = bus.op[1] ? '0 : bus.A;
        end
    end

    // One shift-add step and one restoring-division step per cycle
    always_comb begin
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        prod_d  = {mul_sum, prod_q[XLEN-1:1]};
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        if (rem_sh >= {1'b0, opnd_q}) begin
            rem_d = rem_sh[XLEN-1:0] - opnd_q;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_q  ? -prod_q : prod_q;
        quo_fix  = neg_q  ? -quo_q  : quo_q;
        rem_fix  = rneg_q ? -rem_q  : rem_q;
        case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quo_fix;
            default:                result_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            out_q   <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= bus.op;
                        if (div_zero || div_ovf) begin
                            out_q   <= special_res;
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= '0;
                            opnd_q  <= bus.op[2] ? b_mag : a_mag;
                            prod_q  <= {{XLEN{1'b0}}, b_mag};
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            neg_q   <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Counter at XLEN: iterations finished, apply sign fix-up now
                    if (cnt_q == LAST) begin
                        out_q   <= result_d;
                        state_q <= DONE;
                    end else begin
                        if (op_q[2]) begin
                            quo_q <= quo_d;
                            rem_q <= rem_d;
                        end else begin
                            prod_q <= prod_d;
                        end
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.Out_ALU   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// tb_alu_muldiv : self-checking bench for alu_muldiv (XLEN=32)
// Revision 1.0
// ============================================================================
module tb_alu_muldiv;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    alu_muldiv_if #(.XLEN(32)) bus ();

    alu_muldiv #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; return 32'(sa / sb); end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 32'd0) return a; return 32'(sa % sb); end
            default: begin if (b == 32'd0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        if (o[2] && b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Present a request for one edge, then scramble the operand inputs
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op       = o;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.B        = $urandom;
        bus.op       = 3'($urandom);
    endtask

    // Edges from acceptance until out_valid; returns 100 on time-out
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.Out_ALU !== 32'd0)
                $display("FAIL reset_state: in_ready=%b out_valid=%b Out_ALU=%h, required 0/0/0",
                         bus.in_ready, bus.out_valid, bus.Out_ALU);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0]  d_op  [14] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd4, 3'd6,
                                    3'd4, 3'd6, 3'd4, 3'd6, 3'd2, 3'd5, 3'd7};
        logic [31:0] d_a   [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                    32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd5};
        logic [31:0] d_b   [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd7,
                                    32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'd2, 32'd0, 32'd0};
        logic [31:0] d_res [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'd14, 32'd2,
                                    32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                                    32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        int          d_lat [14] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 1, 1};
        int          lat;
        for (int i = 0; i < 14; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_valid(lat);
            n_total++;
            if (bus.Out_ALU !== d_res[i])
                $display("FAIL directed_%0d_result: op=%0d A=%h B=%h got %h, required %h",
                         i, d_op[i], d_a[i], d_b[i], bus.Out_ALU, d_res[i]);
            else n_pass++;
            n_total++;
            if (lat !== d_lat[i])
                $display("FAIL directed_%0d_latency: got %0d edges, required %0d", i, lat, d_lat[i]);
            else n_pass++;
            retire();
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          lat;
        for (int i = 0; i < 48; i++) begin
            o       = 3'($urandom_range(0, 7));
            a       = rnd_operand();
            b       = rnd_operand();
            exp_res = ref_op(o, a, b);
            issue(o, a, b);
            wait_valid(lat);
            n_total++;
            if (bus.Out_ALU !== exp_res || lat !== ref_lat(o, a, b))
                $display("FAIL random_%0d: op=%0d A=%h B=%h got %h after %0d edges, required %h after %0d",
                         i, o, a, b, bus.Out_ALU, lat, exp_res, ref_lat(o, a, b));
            else n_pass++;
            retire();
        end
    endtask

    task automatic test_hold();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          lat;
        a       = $urandom;
        b       = $urandom;
        exp_res = ref_op(3'd3, a, b);
        issue(3'd3, a, b);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.Out_ALU !== exp_res || bus.in_ready !== 1'b0)
                $display("FAIL hold_cycle_%0d: out_valid=%b Out_ALU=%h in_ready=%b, required 1/%h/0",
                         i, bus.out_valid, bus.Out_ALU, bus.in_ready, exp_res);
            else n_pass++;
        end
        // A request offered on the retiring edge must not be taken
        bus.op       = 3'd0;
        bus.in_valid = 1'b1;
        retire();
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0/1",
                     bus.out_valid, bus.in_ready);
        else n_pass++;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        issue(3'd5, $urandom, $urandom | 32'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_busy: out_valid=%b in_ready=%b, required 0/1",
                     bus.out_valid, bus.in_ready);
        else n_pass++;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL flush_no_result: out_valid seen %0d cycles, required 0", seen);
        else n_pass++;

        @(negedge clk);
        bus.op       = 3'd0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL flush_idle_block: in_ready=%b, required 1", bus.in_ready);
        else n_pass++;

        issue(3'd0, 32'd3, 32'd4);
        wait_valid(lat);
        n_total++;
        if (bus.Out_ALU !== 32'd12 || lat !== 33)
            $display("FAIL flush_then_mul: got %h after %0d edges, required 0000000c after 33",
                     bus.Out_ALU, lat);
        else n_pass++;
        retire();

        issue(3'd0, 32'd3, 32'd5);
        wait_valid(lat);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_done: out_valid=%b in_ready=%b, required 0/1",
                     bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(3'd0, 32'd6, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.Out_ALU !== 32'd0 || bus.in_ready !== 1'b0)
            $display("FAIL reset_mid_busy: out_valid=%b Out_ALU=%h in_ready=%b, required 0/0/0",
                     bus.out_valid, bus.Out_ALU, bus.in_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_mid_release: in_ready=%b, required 1", bus.in_ready);
        else n_pass++;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_valid(lat);
        n_total++;
        if (bus.Out_ALU !== 32'hFFFF_FFFF || lat !== 33)
            $display("FAIL reset_mid_after: got %h after %0d edges, required ffffffff after 33",
                     bus.Out_ALU, lat);
        else n_pass++;
        retire();
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.A         = 32'd0;
        bus.B         = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal values 8..64, even).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port A  input  XLEN  operand 1 (multiplicand/dividend).
REQ-008 SHALL have port B  input  XLEN  operand 2 (multiplier/divisor).
REQ-009 SHALL have port flush  input  1  abort any operation in progress.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Out_ALU  output  XLEN  result.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE) and not rst; out_valid = (state==DONE).
REQ-014 SHALL accept a request on an edge with in_valid and in_ready high, latching op, A, B; A/B changes after acceptance SHALL have no effect.
REQ-015 SHALL, on acceptance of a normal request, enter BUSY with iteration counter 0 and perform exactly one iteration per cycle for XLEN cycles, then enter DONE; out_valid rises XLEN+1 edges after the acceptance edge.
REQ-016 SHALL compute multiply by iterative shift-add on operand magnitudes into a 2*XLEN product; MUL returns product[XLEN-1:0], MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN] after sign correction.
REQ-017 SHALL treat operands as: MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU both unsigned.
REQ-018 SHALL compute divide by restoring division, one quotient bit per iteration, on magnitudes; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-019 SHALL apply sign correction on the BUSY->DONE transition, not as a separate cycle.
REQ-020 SHALL, for B==0 on DIV/DIVU, return all ones; on REM/REMU return A; entering DONE on the edge after acceptance (out_valid 1 edge after acceptance).
REQ-021 SHALL, for DIV with A = most-negative and B = all ones, return A; REM returns 0; also 1-edge latency.
REQ-022 SHALL hold Out_ALU and out_valid stable in DONE until an edge with out_ready high, then return to IDLE; no new request is accepted on that same edge.
REQ-023 SHALL, when flush is high on an edge in BUSY or DONE, return to IDLE on that edge and discard the result; flush in IDLE SHALL block acceptance on that edge.
REQ-024 SHALL give rst priority over flush, and flush over all other transitions.
REQ-025 SHALL keep Out_ALU at its last value outside DONE (value undefined to consumers when out_valid low).

Reset
REQ-026 SHALL, on any edge with rst high (including mid-BUSY/DONE), go to IDLE, clear counter, product/quotient/remainder registers and Out_ALU to 0, out_valid to 0.
REQ-027 SHALL hold in_ready low while rst is high and drive it high on the first cycle after rst deasserts.

Verification (XLEN=32)
REQ-028 SHALL cover: MUL A=7, B=0xFFFFFFFD -> Out_ALU=0xFFFFFFEB, out_valid 33 edges after acceptance; MULH A=B=0x80000000 -> 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 SHALL cover: DIVU 100/7 -> 14, REMU 100/7 -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-030 SHALL cover: DIV A=5, B=0 -> 0xFFFFFFFF and REM A=5, B=0 -> 5, each with out_valid 1 edge after acceptance; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-031 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid and Out_ALU unchanged, in_ready low; out_ready high -> IDLE next edge.
REQ-032 SHALL cover: flush at iteration 10 of a DIVU -> IDLE next edge, no out_valid; following MUL 3*4 -> 12 with normal latency.
REQ-033 SHALL cover: rst asserted mid-BUSY -> next edge out_valid=0, Out_ALU=0, in_ready high first cycle after rst release.
